quad_encoder_gen: RTL and testbench

Quadrature encoder signal generator: the transmit-side counterpart of the ESC's encoder input. Produces A/B quadrature waveforms at a commanded step period and direction, either continuously or for an exact step count. It is used as an on-chip encoder emulator for closed-loop bring-up and loopback test of the ESC speed/direction logic.

---
 rtl/quad_encoder_pkg.sv | 28 ++
 rtl/quad_phase_step.sv | 13 +
 rtl/quad_encoder_gen.sv | 174 +++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_pkg.sv
// Shared types for the quadrature encoder generator: FSM states, phase type and successor tables.
// Combinational helpers only; no latency, no backpressure.
package quad_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MOVE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [1:0] phase_t;

    // Successor tables packed as 4 x 2-bit entries, indexed by the current {A,B} phase.
    // Forward 00->01->11->10->00, reverse 00->10->11->01->00.
    localparam logic [7:0] FWD_SUCC = 8'b10_00_11_01;
    localparam logic [7:0] REV_SUCC = 8'b01_11_00_10;

    function automatic phase_t phase_succ(input phase_t ph, input logic rev);
        logic [2:0] idx;
        idx = {ph, 1'b0};
        if (rev) begin
            return REV_SUCC[idx +: 2];
        end
        return FWD_SUCC[idx +: 2];
    endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Next quadrature phase {A,B} from current phase and direction (0 = forward, 1 = reverse).
// Purely combinational; no backpressure.
module quad_phase_step
    import quad_encoder_pkg::*;
(
    input  phase_t i_phase,
    input  logic   i_dir,
    output phase_t o_next
);

    assign o_next = phase_succ(i_phase, i_dir);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator with continuous run and exact-count move modes, used as an encoder emulator.
// All outputs registered (A/B, step_pulse and position change on the same edge); no backpressure.
module quad_encoder_gen
    import quad_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  run,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] step_period,
    input  logic                  move_start,
    input  logic [DATA_WIDTH-1:0] move_steps,
    output logic                  move_busy,
    output logic                  move_done,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic                  step_pulse,
    output logic [DATA_WIDTH-1:0] position
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_period;
    logic [DATA_WIDTH-1:0] r_remaining;
    logic                  r_move_dir;
    phase_t                r_phase;
    logic [DATA_WIDTH-1:0] r_position;
    logic                  r_step_pulse;
    logic                  r_move_busy;
    logic                  r_move_done;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic [DATA_WIDTH-1:0] w_period_nxt;
    logic [DATA_WIDTH-1:0] w_remaining_nxt;
    logic                  w_move_dir_nxt;
    logic                  w_step;
    logic                  w_step_dir;
    logic                  w_period_zero;
    logic                  w_step_due;
    phase_t                w_phase_nxt;

    assign w_period_zero = (r_period == '0);
    assign w_step_due    = !w_period_zero && (r_count == r_period - ONE);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_period_nxt    = r_period;
        w_remaining_nxt = r_remaining;
        w_move_dir_nxt  = r_move_dir;
        w_step          = 1'b0;
        w_step_dir      = dir;

        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (move_start) begin
                    if (move_steps != '0) begin
                        w_state_nxt     = ST_MOVE;
                        w_period_nxt    = step_period;
                        w_remaining_nxt = move_steps;
                        w_move_dir_nxt  = dir;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (run) begin
                    w_state_nxt  = ST_RUN;
                    w_period_nxt = step_period;
                end
            end

            ST_RUN: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_step_due) begin
                    w_step       = 1'b1;
                    w_count_nxt  = '0;
                    w_period_nxt = step_period;
                end else if (w_period_zero) begin
                    // Stalled: keep sampling so a new period starts counting from zero.
                    w_count_nxt  = '0;
                    w_period_nxt = step_period;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end

            ST_MOVE: begin
                w_step_dir = r_move_dir;
                if (r_remaining == '0) begin
                    w_state_nxt = ST_DONE;
                    w_count_nxt = '0;
                end else if (w_step_due) begin
                    w_step          = 1'b1;
                    w_count_nxt     = '0;
                    w_period_nxt    = step_period;
                    w_remaining_nxt = r_remaining - ONE;
                end else if (w_period_zero) begin
                    w_count_nxt  = '0;
                    w_period_nxt = step_period;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase

        // Disable aborts everything but leaves the emitted waveform and position untouched.
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_step      = 1'b0;
        end
    end

    quad_phase_step u_phase_step (
        .i_phase (r_phase),
        .i_dir   (w_step_dir),
        .o_next  (w_phase_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_period     <= '0;
            r_remaining  <= '0;
            r_move_dir   <= 1'b0;
            r_phase      <= 2'b00;
            r_position   <= '0;
            r_step_pulse <= 1'b0;
            r_move_busy  <= 1'b0;
            r_move_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_period     <= w_period_nxt;
            r_remaining  <= w_remaining_nxt;
            r_move_dir   <= w_move_dir_nxt;
            r_step_pulse <= w_step;
            r_move_busy  <= (w_state_nxt == ST_MOVE);
            r_move_done  <= (w_state_nxt == ST_DONE);
            if (w_step) begin
                r_phase    <= w_phase_nxt;
                r_position <= w_step_dir ? (r_position - ONE) : (r_position + ONE);
            end
        end
    end

    assign encoder_a  = r_phase[1];
    assign encoder_b  = r_phase[0];
    assign step_pulse = r_step_pulse;
    assign position   = r_position;
    assign move_busy  = r_move_busy;
    assign move_done  = r_move_done;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen (DATA_WIDTH=8): scoreboard of expected steps checked on each step_pulse.
module tb_quad_encoder_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       run;
    logic       dir;
    logic [7:0] step_period;
    logic       move_start;
    logic [7:0] move_steps;
    logic       move_busy;
    logic       move_done;
    logic       encoder_a;
    logic       encoder_b;
    logic       step_pulse;
    logic [7:0] position;

    quad_encoder_gen #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .run         (run),
        .dir         (dir),
        .step_period (step_period),
        .move_start  (move_start),
        .move_steps  (move_steps),
        .move_busy   (move_busy),
        .move_done   (move_done),
        .encoder_a   (encoder_a),
        .encoder_b   (encoder_b),
        .step_pulse  (step_pulse),
        .position    (position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ab;
        logic [7:0] pos;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] m_ab    = 2'b00;
    logic [7:0] m_pos   = 8'd0;
    logic [1:0] prev_ab = 2'b00;

    function automatic logic [1:0] succ(input logic [1:0] ab, input logic d);
        case ({d, ab})
            3'b0_00: return 2'b01;
            3'b0_01: return 2'b11;
            3'b0_11: return 2'b10;
            3'b0_10: return 2'b00;
            3'b1_00: return 2'b10;
            3'b1_10: return 2'b11;
            3'b1_11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int n, input int spacing, input logic d, input int first);
        for (int k = 0; k < n; k++) begin
            m_ab  = succ(m_ab, d);
            m_pos = d ? (m_pos - 8'd1) : (m_pos + 8'd1);
            sb.push_back('{m_ab, m_pos, first + spacing * k});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Step monitor: every A/B change must be a single-bit step flagged by step_pulse and expected by the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && (step_pulse || {encoder_a, encoder_b} != prev_ab)) begin
            chk("step_pulse_on_ab_change", int'(step_pulse), 1);
            chk("single_bit_change", $countones({encoder_a, encoder_b} ^ prev_ab), 1);
            if (sb.size() == 0) begin
                chk("unexpected_step", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("step_ab", int'({encoder_a, encoder_b}), int'(e.ab));
                chk("step_pos", int'(position), int'(e.pos));
                chk("step_cycle", cyc, e.cyc);
            end
        end
        prev_ab = {encoder_a, encoder_b};
    end

    initial begin
        reset = 1'b0; enable = 1'b0; run = 1'b0; dir = 1'b0;
        move_start = 1'b0; step_period = 8'd0; move_steps = 8'd0;
        tick(3);
        chk("rst_a", int'(encoder_a), 0);
        chk("rst_b", int'(encoder_b), 0);
        chk("rst_pos", int'(position), 0);
        chk("rst_step", int'(step_pulse), 0);
        chk("rst_busy", int'(move_busy), 0);
        chk("rst_done", int'(move_done), 0);
        reset = 1'b1; enable = 1'b1;
        tick(1);

        // Continuous forward at period 4, then reversal.
        step_period = 8'd4; run = 1'b1;
        push(4, 4, 1'b0, cyc + 5);
        tick(17);
        dir = 1'b1;
        push(2, 4, 1'b1, cyc + 4);
        tick(8);
        run = 1'b0; dir = 1'b0;
        tick(4);
        chk("run_stop_pos", int'(position), 2);
        chk("run_stop_ab", int'({encoder_a, encoder_b}), 3);

        // Counted move of 5 steps at period 3; run/dir changes ignored.
        move_start = 1'b1; move_steps = 8'd5; step_period = 8'd3;
        push(5, 3, 1'b0, cyc + 4);
        tick(1);
        move_start = 1'b0; dir = 1'b1; run = 1'b1;
        chk("move_busy_start", int'(move_busy), 1);
        tick(15);
        run = 1'b0; dir = 1'b0;
        chk("move_busy_last", int'(move_busy), 1);
        chk("move_done_early", int'(move_done), 0);
        tick(1);
        chk("move_done_pulse", int'(move_done), 1);
        chk("move_busy_done", int'(move_busy), 0);
        tick(1);
        chk("move_done_single", int'(move_done), 0);
        chk("move_pos", int'(position), 7);

        // Period 8 -> 2 mid-step, then 0 freezes.
        step_period = 8'd8; run = 1'b1;
        push(1, 8, 1'b0, cyc + 9);
        push(2, 2, 1'b0, cyc + 11);
        tick(4);
        step_period = 8'd2;
        tick(8);
        step_period = 8'd0;
        tick(12);
        chk("period0_run_pos", int'(position), 10);
        run = 1'b0;
        tick(2);

        // Move with period 0 stalls busy until a period arrives.
        move_start = 1'b1; move_steps = 8'd2;
        tick(1);
        move_start = 1'b0;
        tick(10);
        chk("stall_busy", int'(move_busy), 1);
        chk("stall_done", int'(move_done), 0);
        chk("stall_pos", int'(position), 10);
        step_period = 8'd1;
        push(2, 1, 1'b0, cyc + 2);
        tick(4);
        chk("stall_move_done", int'(move_done), 1);
        tick(1);
        chk("stall_move_done_clear", int'(move_done), 0);

        // Abort a move with enable=0.
        step_period = 8'd4; move_steps = 8'd10; move_start = 1'b1;
        push(2, 4, 1'b0, cyc + 5);
        tick(1);
        move_start = 1'b0;
        tick(9);
        enable = 1'b0;
        tick(1);
        chk("abort_busy", int'(move_busy), 0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", int'(move_done), 0);
            tick(1);
        end
        chk("abort_pos", int'(position), 14);
        chk("abort_ab", int'({encoder_a, encoder_b}), 3);
        move_start = 1'b1; move_steps = 8'd3;
        tick(1);
        move_start = 1'b0;
        chk("disabled_start_busy", int'(move_busy), 0);
        tick(3);
        chk("disabled_start_pos", int'(position), 14);
        enable = 1'b1;
        tick(2);
        chk("reenable_busy", int'(move_busy), 0);

        // Reset mid-run on an edge where a step would fire.
        step_period = 8'd3; run = 1'b1;
        push(2, 3, 1'b0, cyc + 4);
        tick(9);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_ab", int'({encoder_a, encoder_b}), 0);
        chk("mid_rst_pos", int'(position), 0);
        chk("mid_rst_step", int'(step_pulse), 0);
        chk("mid_rst_busy", int'(move_busy), 0);
        m_ab = 2'b00; m_pos = 8'd0;
        run = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);

        // Wrap: 128 forward steps at period 1.
        step_period = 8'd1; run = 1'b1;
        push(128, 1, 1'b0, cyc + 2);
        tick(129);
        run = 1'b0;
        chk("wrap_pos", int'(position), 128);
        tick(3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
